// File: rtl/axi_lite_slave_regs_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_slave_regs_if : AXI4-Lite bus bundle (AR/R/AW/W/B channels)
// Rev 1.0
// ---------------------------------------------------------------------------
interface axi_lite_slave_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_slave_regs : AXI4-Lite register bank with per-register write pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module axi_lite_slave_regs #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi_lite_slave_regs_if.slave           bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam int         NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t w_state;
  rstate_t r_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [IDX_W-1:0]      aw_live_idx;
  logic [IDX_W-1:0]      ar_idx;
  logic                  aw_live_ok;
  logic                  ar_ok;

  logic                  aw_held;
  logic                  w_held;
  logic [IDX_W-1:0]      aw_idx_h;
  logic                  aw_ok_h;
  logic [DATA_WIDTH-1:0] wdata_h;
  logic [NUM_BYTES-1:0]  wstrb_h;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic [IDX_W-1:0]      cm_idx;
  logic                  cm_ok;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [NUM_BYTES-1:0]  cm_strb;

  assign aw_addr     = bus.awaddr;
  assign ar_addr     = bus.araddr;
  assign aw_live_idx = aw_addr[2 +: IDX_W];
  assign ar_idx      = ar_addr[2 +: IDX_W];
  // Anything above the register window is out of range; the low two bits are ignored.
  assign aw_live_ok  = ((aw_addr >> (IDX_W + 2)) == '0);
  assign ar_ok       = ((ar_addr >> (IDX_W + 2)) == '0);

  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  // A beat handshaking this cycle takes priority over (and excludes) its held copy.
  assign cm_idx  = aw_hs ? aw_live_idx : aw_idx_h;
  assign cm_ok   = aw_hs ? aw_live_ok  : aw_ok_h;
  assign cm_data = w_hs  ? bus.wdata   : wdata_h;
  assign cm_strb = w_hs  ? bus.wstrb   : wstrb_h;

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      w_state     <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
      wr_pulse    <= '0;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_idx_h    <= '0;
      aw_ok_h     <= 1'b0;
      wdata_h     <= '0;
      wstrb_h     <= '0;
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            if (cm_ok) begin
              for (int b = 0; b < NUM_BYTES; b++) begin
                if (cm_strb[b]) regs[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
              end
              wr_pulse[cm_idx] <= 1'b1;
              bus.bresp        <= RESP_OKAY;
            end else begin
              bus.bresp <= RESP_SLVERR;
            end
            bus.bvalid  <= 1'b1;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            w_state     <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held  <= 1'b1;
              aw_idx_h <= aw_live_idx;
              aw_ok_h  <= aw_live_ok;
            end
            if (w_hs) begin
              w_held  <= 1'b1;
              wdata_h <= bus.wdata;
              wstrb_h <= bus.wstrb;
            end
            bus.awready <= !(aw_held || aw_hs);
            bus.wready  <= !(w_held || w_hs);
          end
        end
        W_RESP: begin
          if (bus.bvalid && bus.bready) begin
            bus.bvalid  <= 1'b0;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Reads sample regs before any same-edge write lands, so they see the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.arvalid && bus.arready) begin
            bus.rdata   <= ar_ok ? regs[ar_idx] : '0;
            bus.rresp   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            bus.rvalid  <= 1'b1;
            bus.arready <= 1'b0;
            r_state     <= R_DATA;
          end else begin
            bus.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (bus.rvalid && bus.rready) begin
            bus.rvalid  <= 1'b0;
            bus.arready <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regq
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regs : directed bench for the AXI4-Lite register bank
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

  logic         aclk;
  logic         areset;
  logic [511:0] reg_q;
  logic [15:0]  wr_pulse;
  int           n_pass;
  int           n_total;
  logic [31:0]  got_d;
  logic [1:0]   got_r;
  logic [511:0] saved_q;

  axi_lite_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_slave_regs #(.NUM_REGS(16), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .bus      (bus),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    resp = bus.bresp;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    tick();
    data = bus.rdata; resp = bus.rresp;
    bus.arvalid = 1'b0;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_total++; if (bus.arready !== 1'b0) $display("FAIL rst_arready: got %0b expected 0", bus.arready); else n_pass++;
    n_total++; if (bus.awready !== 1'b0) $display("FAIL rst_awready: got %0b expected 0", bus.awready); else n_pass++;
    n_total++; if (bus.wready !== 1'b0) $display("FAIL rst_wready: got %0b expected 0", bus.wready); else n_pass++;
    n_total++; if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) $display("FAIL rst_valids: got r=%0b b=%0b expected 0 0", bus.rvalid, bus.bvalid); else n_pass++;
    n_total++; if (bus.rdata !== 32'h0 || bus.rresp !== 2'b00 || bus.bresp !== 2'b00) $display("FAIL rst_resp: got rdata=%h rresp=%0b bresp=%0b expected 0", bus.rdata, bus.rresp, bus.bresp); else n_pass++;
    n_total++; if (reg_q !== '0 || wr_pulse !== 16'h0) $display("FAIL rst_regs: got wr_pulse=%h reg0=%h expected 0", wr_pulse, reg_q[31:0]); else n_pass++;
    areset = 1'b0;
    tick();
    n_total++; if ({bus.arready, bus.awready, bus.wready} !== 3'b111) $display("FAIL rst_release_readies: got %b expected 111", {bus.arready, bus.awready, bus.wready}); else n_pass++;
  endtask

  task automatic test_aw_w_same();
    bus.awaddr = 32'h8; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    n_total++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) $display("FAIL same_b: got bvalid=%0b bresp=%0b expected 1 00", bus.bvalid, bus.bresp); else n_pass++;
    n_total++; if (wr_pulse !== 16'h0004) $display("FAIL same_pulse: got %h expected 0004", wr_pulse); else n_pass++;
    n_total++; if (reg_q[95:64] !== 32'hDEADBEEF) $display("FAIL same_reg2: got %h expected deadbeef", reg_q[95:64]); else n_pass++;
    n_total++; if (bus.awready !== 1'b0 || bus.wready !== 1'b0) $display("FAIL same_readies_resp: got %0b%0b expected 00", bus.awready, bus.wready); else n_pass++;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    n_total++; if (bus.bvalid !== 1'b0 || wr_pulse !== 16'h0) $display("FAIL same_after_b: got bvalid=%0b pulse=%h expected 0 0", bus.bvalid, wr_pulse); else n_pass++;
    n_total++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1) $display("FAIL same_readies_back: got %0b%0b expected 11", bus.awready, bus.wready); else n_pass++;
    bus.bready = 1'b0;
  endtask

  task automatic test_w_first();
    bus.wdata = 32'h11223344; bus.wstrb = 4'h5; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (bus.wready !== 1'b0 || bus.awready !== 1'b1) $display("FAIL wfirst_wait_readies: got w=%0b aw=%0b expected 0 1", bus.wready, bus.awready); else n_pass++;
      n_total++; if (bus.bvalid !== 1'b0 || reg_q[31:0] !== 32'h0) $display("FAIL wfirst_early_commit: got bvalid=%0b reg0=%h expected 0 0", bus.bvalid, reg_q[31:0]); else n_pass++;
      if (i < 2) tick();
    end
    bus.awaddr = 32'h0; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    n_total++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) $display("FAIL wfirst_b: got bvalid=%0b bresp=%0b expected 1 00", bus.bvalid, bus.bresp); else n_pass++;
    n_total++; if (reg_q[31:0] !== 32'h00220044) $display("FAIL wfirst_reg0: got %h expected 00220044", reg_q[31:0]); else n_pass++;
    n_total++; if (wr_pulse !== 16'h0001) $display("FAIL wfirst_pulse: got %h expected 0001", wr_pulse); else n_pass++;
    tick();
    tick();
    n_total++; if (bus.bvalid !== 1'b0) $display("FAIL wfirst_single_resp: got bvalid=%0b expected 0", bus.bvalid); else n_pass++;
    bus.bready = 1'b0;
  endtask

  task automatic test_backpressure();
    axi_write(32'h8, 32'hA5A5A5A5, 4'hF, got_r);
    bus.araddr = 32'h8; bus.arvalid = 1'b1; bus.rready = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA5A5A5A5 || bus.rresp !== 2'b00) $display("FAIL bp_hold: got rvalid=%0b rdata=%h rresp=%0b expected 1 a5a5a5a5 00", bus.rvalid, bus.rdata, bus.rresp); else n_pass++;
      n_total++; if (bus.arready !== 1'b0) $display("FAIL bp_arready_low: got %0b expected 0", bus.arready); else n_pass++;
      tick();
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    n_total++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) $display("FAIL bp_release: got rvalid=%0b arready=%0b expected 0 1", bus.rvalid, bus.arready); else n_pass++;
  endtask

  task automatic test_out_of_range();
    saved_q = reg_q;
    bus.awaddr = 32'h40; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n_total++; if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b10) $display("FAIL oor_bresp: got bvalid=%0b bresp=%0b expected 1 10", bus.bvalid, bus.bresp); else n_pass++;
    n_total++; if (wr_pulse !== 16'h0) $display("FAIL oor_pulse: got %h expected 0000", wr_pulse); else n_pass++;
    n_total++; if (reg_q !== saved_q) $display("FAIL oor_regs_changed: got reg0=%h reg2=%h expected 00220044 a5a5a5a5", reg_q[31:0], reg_q[95:64]); else n_pass++;
    tick();
    bus.bready = 1'b0;
    axi_read(32'h40, got_d, got_r);
    n_total++; if (got_r !== 2'b10 || got_d !== 32'h0) $display("FAIL oor_read: got rresp=%0b rdata=%h expected 10 00000000", got_r, got_d); else n_pass++;
    axi_read(32'h0B, got_d, got_r);
    n_total++; if (got_r !== 2'b00 || got_d !== 32'hA5A5A5A5) $display("FAIL unaligned_read: got rresp=%0b rdata=%h expected 00 a5a5a5a5", got_r, got_d); else n_pass++;
  endtask

  task automatic test_simultaneous();
    axi_write(32'h4, 32'h1, 4'hF, got_r);
    bus.araddr = 32'h4; bus.arvalid = 1'b1; bus.rready = 1'b0;
    bus.awaddr = 32'h4; bus.wdata = 32'h2; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n_total++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h1) $display("FAIL sim_old_value: got rvalid=%0b rdata=%h expected 1 00000001", bus.rvalid, bus.rdata); else n_pass++;
    n_total++; if (reg_q[63:32] !== 32'h2 || bus.bvalid !== 1'b1) $display("FAIL sim_write: got reg1=%h bvalid=%0b expected 00000002 1", reg_q[63:32], bus.bvalid); else n_pass++;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    axi_read(32'h4, got_d, got_r);
    n_total++; if (got_d !== 32'h2 || got_r !== 2'b00) $display("FAIL sim_reread: got rdata=%h rresp=%0b expected 00000002 00", got_d, got_r); else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Pending B and R responses, then reset.
    bus.araddr = 32'h4; bus.arvalid = 1'b1; bus.rready = 1'b0;
    bus.awaddr = 32'hC; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n_total++; if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1) $display("FAIL rm_pending: got bvalid=%0b rvalid=%0b expected 1 1", bus.bvalid, bus.rvalid); else n_pass++;
    areset = 1'b1;
    tick();
    n_total++; if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0) $display("FAIL rm_ctrl: got %b expected 00000", {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}); else n_pass++;
    n_total++; if (bus.rdata !== 32'h0 || reg_q !== '0 || wr_pulse !== 16'h0) $display("FAIL rm_data: got rdata=%h reg3=%h pulse=%h expected 0 0 0", bus.rdata, reg_q[127:96], wr_pulse); else n_pass++;
    areset = 1'b0;
    tick();
    n_total++; if ({bus.arready, bus.awready, bus.wready} !== 3'b111) $display("FAIL rm_release: got %b expected 111", {bus.arready, bus.awready, bus.wready}); else n_pass++;
    // Held AW discarded by reset: its W partner arrives on the reset edge.
    bus.awaddr = 32'h14; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    n_total++; if (bus.awready !== 1'b0 || bus.wready !== 1'b1) $display("FAIL rm_aw_held: got aw=%0b w=%0b expected 0 1", bus.awready, bus.wready); else n_pass++;
    bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1; areset = 1'b1;
    tick();
    bus.wvalid = 1'b0; areset = 1'b0;
    tick();
    n_total++; if (bus.bvalid !== 1'b0 || reg_q !== '0 || bus.awready !== 1'b1) $display("FAIL rm_no_write: got bvalid=%0b reg5=%h awready=%0b expected 0 0 1", bus.bvalid, reg_q[191:160], bus.awready); else n_pass++;
    bus.wdata = 32'h99; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    n_total++; if (bus.bvalid !== 1'b0 || bus.wready !== 1'b0) $display("FAIL rm_w_only: got bvalid=%0b wready=%0b expected 0 0", bus.bvalid, bus.wready); else n_pass++;
    bus.awaddr = 32'h18; bus.awvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    n_total++; if (wr_pulse !== 16'h0040 || reg_q[223:192] !== 32'h99 || reg_q[191:160] !== 32'h0) $display("FAIL rm_fresh_write: got pulse=%h reg6=%h reg5=%h expected 0040 00000099 0", wr_pulse, reg_q[223:192], reg_q[191:160]); else n_pass++;
    tick();
    bus.bready = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    areset = 1'b1;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    test_reset();
    test_aw_w_same();
    test_w_first();
    test_backpressure();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within 200000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire
